accmat_dac_serializer: RTL and testbench

Audio output stage downstream of the accelerator matrix.
- Accepts 24-bit samples over a toggle handshake and buffers them in a small FIFO.
- Serializes each sample in I2S format onto the codec DAC data pin, timed by the codec-supplied BCLK and DACLRCK.
- Each mono sample is sent on both the left and right channels of one LRCK frame.

---
 rtl/accmat_audio_pkg.sv | 14 +
 rtl/accmat_sample_fifo.sv | 52 +++++
 rtl/accmat_dac_serializer.sv | 171 +++++++++++++++++
 tb/tb_accmat_dac_serializer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accmat_audio_pkg.sv
// Shared constants and types for the accmat audio output path.
package accmat_audio_pkg;

    localparam int SAMPLE_W_DEFAULT = 24;
    localparam int I2S_DELAY_BITS   = 1;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SHIFT,
        PAD
    } dac_state_t;

endpackage

// File: rtl/accmat_sample_fifo.sv
// Synchronous sample FIFO; a pop frees its slot for a push in the same cycle.
module accmat_sample_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (level == '0);
    assign full      = (level == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: the level counter decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/accmat_dac_serializer.sv
// I2S DAC serializer: toggle-handshake sample capture, FIFO, mono-to-stereo framing.
// Sticky underrun/overflow flags exist only when ACCMAT_DAC_STATUS_EN is defined.
module accmat_dac_serializer
    import accmat_audio_pkg::*;
#(
    parameter int SAMPLE_W    = SAMPLE_W_DEFAULT,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic [SAMPLE_W-1:0]         sample_i,
    input  logic                        sample_toggle_i,
    output logic                        ack_toggle_o,
    input  logic                        audio_o_BCLK,
    input  logic                        audio_o_DACLRCK,
    output logic                        audio_o_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        underrun_o,
    output logic                        overflow_o,
    input  logic                        status_clr_i
);

    localparam int CNT_W = $clog2(SAMPLE_W);
    localparam int DLY_W = 2;

    logic [SYNC_STAGES-1:0] tog_sync, bclk_sync, lrck_sync;
    logic                   tog_d, bclk_d, lrck_d;
    logic                   tog_edge, bclk_fall, lrck_edge, lrck_fall;

    logic [SAMPLE_W-1:0]    fifo_head, held_q, held_next;
    logic                   fifo_full, fifo_empty;

    dac_state_t             state, state_next;
    logic [SAMPLE_W-1:0]    shift_reg, shift_next;
    logic [CNT_W-1:0]       bit_cnt, cnt_next;
    logic [DLY_W-1:0]       dly_cnt, dly_next;
    logic                   dacdat_next;

    // Each synchronizer shifts in at bit 0; the top bit is the settled value.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            tog_sync     <= '0;
            bclk_sync    <= '0;
            lrck_sync    <= '0;
            tog_d        <= 1'b0;
            bclk_d       <= 1'b0;
            lrck_d       <= 1'b0;
            ack_toggle_o <= 1'b0;
        end else begin
            tog_sync     <= SYNC_STAGES'({tog_sync, sample_toggle_i});
            bclk_sync    <= SYNC_STAGES'({bclk_sync, audio_o_BCLK});
            lrck_sync    <= SYNC_STAGES'({lrck_sync, audio_o_DACLRCK});
            tog_d        <= tog_sync[SYNC_STAGES-1];
            bclk_d       <= bclk_sync[SYNC_STAGES-1];
            lrck_d       <= lrck_sync[SYNC_STAGES-1];
            ack_toggle_o <= tog_d;
        end
    end

    assign tog_edge  = tog_sync[SYNC_STAGES-1] ^ tog_d;
    assign bclk_fall = bclk_d & ~bclk_sync[SYNC_STAGES-1];
    assign lrck_edge = lrck_sync[SYNC_STAGES-1] ^ lrck_d;
    assign lrck_fall = lrck_d & ~lrck_sync[SYNC_STAGES-1];

    accmat_sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .reset     (reset_reset),
        .push      (tog_edge),
        .push_data (sample_i),
        .pop       (lrck_fall),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level_o)
    );

    // An empty FIFO at left-frame start sends silence rather than repeating stale audio.
    assign held_next = lrck_fall ? (fifo_empty ? '0 : fifo_head) : held_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            held_q         <= '0;
            state          <= IDLE;
            shift_reg      <= '0;
            bit_cnt        <= '0;
            dly_cnt        <= '0;
            audio_o_DACDAT <= 1'b0;
        end else begin
            held_q         <= held_next;
            state          <= state_next;
            shift_reg      <= shift_next;
            bit_cnt        <= cnt_next;
            dly_cnt        <= dly_next;
            audio_o_DACDAT <= dacdat_next;
        end
    end

    // An LRCK edge always restarts the word and masks a coincident BCLK fall.
    always_comb begin
        state_next  = state;
        shift_next  = shift_reg;
        cnt_next    = bit_cnt;
        dly_next    = dly_cnt;
        dacdat_next = audio_o_DACDAT;
        if (lrck_edge) begin
            state_next  = DELAY;
            shift_next  = held_next;
            dly_next    = DLY_W'(I2S_DELAY_BITS - 1);
            dacdat_next = 1'b0;
        end else if (bclk_fall) begin
            case (state)
                DELAY: begin
                    if (dly_cnt != '0) begin
                        dly_next    = dly_cnt - DLY_W'(1);
                        dacdat_next = 1'b0;
                    end else begin
                        dacdat_next = shift_reg[SAMPLE_W-1];
                        shift_next  = shift_reg << 1;
                        cnt_next    = CNT_W'(SAMPLE_W - 1);
                        state_next  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == '0) begin
                        dacdat_next = 1'b0;
                        state_next  = PAD;
                    end else begin
                        dacdat_next = shift_reg[SAMPLE_W-1];
                        shift_next  = shift_reg << 1;
                        cnt_next    = bit_cnt - CNT_W'(1);
                    end
                end
                default: dacdat_next = 1'b0;
            endcase
        end
    end

`ifdef ACCMAT_DAC_STATUS_EN
    logic underrun_q, overflow_q;
    logic underrun_set, overflow_set;

    // A push at full only overflows when no pop frees a slot in that cycle.
    assign underrun_set = lrck_fall && fifo_empty;
    assign overflow_set = tog_edge && fifo_full && !lrck_fall;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (underrun_set)      underrun_q <= 1'b1;
            else if (status_clr_i) underrun_q <= 1'b0;
            if (overflow_set)      overflow_q <= 1'b1;
            else if (status_clr_i) overflow_q <= 1'b0;
        end
    end

    assign underrun_o = underrun_q;
    assign overflow_o = overflow_q;
`else
    logic unused_status;
    assign unused_status = status_clr_i ^ fifo_full;
    assign underrun_o    = 1'b0;
    assign overflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_accmat_dac_serializer.sv
// Directed bench for accmat_dac_serializer: handshake, FIFO, I2S framing, reset.
module tb_accmat_dac_serializer;

`ifdef ACCMAT_DAC_STATUS_EN
    localparam logic FLAG_ON = 1'b1;
`else
    localparam logic FLAG_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] sample = '0;
    logic        tog = 1'b0;
    logic        ack;
    logic        bclk = 1'b1;
    logic        lrck = 1'b1;
    logic        dacdat;
    logic [3:0]  level;
    logic        underrun;
    logic        overflow;
    logic        clr = 1'b0;

    int   errors = 0;
    int   checks = 0;
    logic cap [0:127];
    int   cap_n = 0;

    always #5 clk = ~clk;

    accmat_dac_serializer dut (
        .clk_clk         (clk),
        .reset_reset     (reset),
        .sample_i        (sample),
        .sample_toggle_i (tog),
        .ack_toggle_o    (ack),
        .audio_o_BCLK    (bclk),
        .audio_o_DACLRCK (lrck),
        .audio_o_DACDAT  (dacdat),
        .fifo_level_o    (level),
        .underrun_o      (underrun),
        .overflow_o      (overflow),
        .status_clr_i    (clr)
    );

    // Codec model: LRCK changes on BCLK fall, DACDAT sampled on BCLK rise.
    task automatic codec_bits(input logic lr, input int n);
        for (int i = 0; i < n; i++) begin
            bclk = 1'b0;
            lrck = lr;
            #160;
            bclk = 1'b1;
            cap[cap_n] = dacdat;
            cap_n++;
            #160;
        end
    endtask

    task automatic codec_frame();
        @(negedge clk);
        cap_n = 0;
        codec_bits(1'b0, 32);
        codec_bits(1'b1, 32);
    endtask

    function automatic logic [23:0] word_at(input int start);
        logic [23:0] w;
        for (int i = 0; i < 24; i++) w[23-i] = cap[start+i];
        return w;
    endfunction

    function automatic int nonzero_in(input int start, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (cap[start+i] !== 1'b0) c++;
        return c;
    endfunction

    task automatic push_sample(input logic [23:0] d);
        bit ok = 1'b0;
        @(negedge clk);
        sample = d;
        tog    = ~tog;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (ack === tog) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_ack: ack=%b required %b", ack, tog);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL reset_dacdat: got %b want 0", dacdat); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_idle();
        codec_frame();
        checks++; if (nonzero_in(0, 64) != 0) begin errors++; $display("FAIL idle_dacdat: %0d nonzero bits, want 0", nonzero_in(0, 64)); end
        checks++; if (underrun !== FLAG_ON) begin errors++; $display("FAIL idle_underrun: got %b want %b", underrun, FLAG_ON); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL idle_level: got %0d want 0", level); end
    endtask

    task automatic test_handshake();
        pulse_clear();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL clear_underrun: got %b want 0", underrun); end
        @(negedge clk);
        sample = 24'hA50F3C;
        tog    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_early: got %b want 0", ack); end
        @(posedge clk);
        #1;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ack_latency: got %b want 1", ack); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL ack_level: got %0d want 1", level); end
    endtask

    task automatic test_single_sample();
        codec_frame();
        checks++; if (cap[0] !== 1'b0) begin errors++; $display("FAIL left_delay_bit: got %b want 0", cap[0]); end
        checks++; if (word_at(1) !== 24'hA50F3C) begin errors++; $display("FAIL left_word: got %h want a50f3c", word_at(1)); end
        checks++; if (nonzero_in(25, 8) != 0) begin errors++; $display("FAIL left_pad: %0d nonzero bits, want 0", nonzero_in(25, 8)); end
        checks++; if (word_at(33) !== 24'hA50F3C) begin errors++; $display("FAIL right_word: got %h want a50f3c", word_at(33)); end
        checks++; if (nonzero_in(57, 7) != 0) begin errors++; $display("FAIL right_pad: %0d nonzero bits, want 0", nonzero_in(57, 7)); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL single_underrun: got %b want 0", underrun); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL single_level: got %0d want 0", level); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) push_sample(24'(i * 24'h111111));
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level: got %0d want 8", level); end
        checks++; if (overflow !== FLAG_ON) begin errors++; $display("FAIL overflow_set: got %b want %b", overflow, FLAG_ON); end
        pulse_clear();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_overflow: got %b want 0", overflow); end
        // Toggle and LRCK fall land together: pop and push in the same cycle at full.
        @(negedge clk);
        sample = 24'hABCDEF;
        tog    = ~tog;
        cap_n  = 0;
        codec_bits(1'b0, 32);
        codec_bits(1'b1, 32);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow: got %b want 0", overflow); end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL pushpop_level: got %0d want 8", level); end
        checks++; if (ack !== tog) begin errors++; $display("FAIL pushpop_ack: got %b want %b", ack, tog); end
        checks++; if (word_at(1) !== 24'h111111) begin errors++; $display("FAIL pushpop_word: got %h want 111111", word_at(1)); end
        for (int k = 2; k <= 8; k++) begin
            codec_frame();
            checks++;
            if (word_at(1) !== 24'(k * 24'h111111)) begin
                errors++;
                $display("FAIL drain_word_%0d: got %h want %h", k, word_at(1), 24'(k * 24'h111111));
            end
        end
        codec_frame();
        checks++; if (word_at(1) !== 24'hABCDEF) begin errors++; $display("FAIL drain_last: got %h want abcdef", word_at(1)); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL drain_level: got %0d want 0", level); end
    endtask

    task automatic test_short_frame();
        logic [8:0] part;
        push_sample(24'hC35A96);
        @(negedge clk);
        cap_n = 0;
        codec_bits(1'b0, 10);
        codec_bits(1'b1, 32);
        for (int i = 0; i < 9; i++) part[8-i] = cap[1+i];
        checks++; if (part !== 9'h186) begin errors++; $display("FAIL short_partial: got %h want 186", part); end
        checks++; if (cap[10] !== 1'b0) begin errors++; $display("FAIL short_delay_bit: got %b want 0", cap[10]); end
        checks++; if (word_at(11) !== 24'hC35A96) begin errors++; $display("FAIL short_restart: got %h want c35a96", word_at(11)); end
        checks++; if (nonzero_in(35, 7) != 0) begin errors++; $display("FAIL short_pad: %0d nonzero bits, want 0", nonzero_in(35, 7)); end
    endtask

    task automatic test_reset_mid_shift();
        // Bare LRCK fall with an empty FIFO raises underrun before the reset.
        @(negedge clk);
        lrck = 1'b0;
        repeat (10) @(negedge clk);
        lrck = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (underrun !== FLAG_ON) begin errors++; $display("FAIL pre_reset_underrun: got %b want %b", underrun, FLAG_ON); end
        push_sample(24'hFFFFFF);
        push_sample(24'h123456);
        @(negedge clk);
        cap_n = 0;
        codec_bits(1'b0, 13);
        checks++; if (cap[12] !== 1'b1) begin errors++; $display("FAIL mid_bit12: got %b want 1", cap[12]); end
        @(negedge clk);
        reset = 1'b1;
        tog   = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL mid_reset_dacdat: got %b want 0", dacdat); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL mid_reset_level: got %0d want 0", level); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mid_reset_underrun: got %b want 0", underrun); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        cap_n = 0;
        codec_bits(1'b0, 19);
        codec_bits(1'b1, 32);
        checks++; if (nonzero_in(0, 51) != 0) begin errors++; $display("FAIL post_reset_silence: %0d nonzero bits, want 0", nonzero_in(0, 51)); end
        push_sample(24'h5A5A5A);
        codec_frame();
        checks++; if (word_at(1) !== 24'h5A5A5A) begin errors++; $display("FAIL resume_left: got %h want 5a5a5a", word_at(1)); end
        checks++; if (word_at(33) !== 24'h5A5A5A) begin errors++; $display("FAIL resume_right: got %h want 5a5a5a", word_at(33)); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL resume_underrun: got %b want 0", underrun); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_handshake();
        test_single_sample();
        test_overflow();
        test_short_frame();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] timeout");
    end

endmodule
